sprite_ram_dp: RTL and testbench
================================

# sprite_ram_dp

Parametrised dual-port sprite pattern store for the graphics pipeline. It sits between the CPU-side bus slave and the sprite renderer. Port 0 is a wide, chip-selected, byte-enabled bus port that packs RATIO sprite lines per word. Port 1 is a narrow, one-line-per-access port used by the renderer. The block adds two things: a registered read path with valid strobes, and a sequential clear engine. The clear engine replaces an all-at-once reset of the array, so the storage maps onto block RAM.

## Interface
Parameters:
- SPRITES, 128, number of sprites; power of 2.
- LINES, 16, lines per sprite; multiple of RATIO.
- LINE_W, 16, bits per sprite line; multiple of 8.
- RATIO, 2, lines per port-0 word; power of 2. W0 = LINE_W*RATIO.
- CLEAR_ON_RESET, 1, 1 = run the clear engine after reset release.

Ports (SI = $clog2(SPRITES), LI = $clog2(LINES), WI = $clog2(LINES/RATIO)):
- CLK_100  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr0_sprite_index  in  SI  port-0 sprite.
- addr0_sprite_word  in  WI  port-0 word within sprite.
- be0  in  W0/8  port-0 byte enables.
- data_w0  in  W0  port-0 write data.
- r0, w0, cs0  in  1  port-0 read, write, chip select.
- data_r0  out  W0  port-0 read data, registered.
- rvalid0  out  1  data_r0 valid this cycle.
- addr1_sprite_index  in  SI  port-1 sprite.
- addr1_sprite_line  in  LI  port-1 line.
- be1  in  LINE_W/8  port-1 byte enables.
- data_w1  in  LINE_W  port-1 write data.
- r1, w1  in  1  port-1 read, write.
- data_r1  out  LINE_W  port-1 read data, registered.
- rvalid1  out  1  data_r1 valid this cycle.
- clear_req  in  1  single-cycle request to zero the whole array.
- clear_busy  out  1  clear engine active.

## Operation
- Storage: SPRITES*LINES words of LINE_W bits. Linear line address = sprite*LINES + line.
- Port-0 word k of a sprite maps to lines RATIO*k .. RATIO*k+RATIO-1. Line RATIO*k+i occupies data bits [i*LINE_W +: LINE_W].
- Byte enable j covers data bits [8j+7:8j] on each port.
- Port 0 is active only when cs0=1. Port 1 has no select.
- r and w high together on the same port: the read wins and the write is dropped.
- Write collision (both ports write the same line in the same cycle): port 0's enabled bytes win. Bytes enabled only on port 1 are written from port 1.
- Clear FSM has two states, IDLE and CLEAR:
  - On reset the state becomes CLEAR if CLEAR_ON_RESET=1, otherwise IDLE. The line counter resets to 0.
  - IDLE -> CLEAR when clear_req=1; the counter loads 0.
  - In CLEAR, one line per cycle is written to zero, in counter order.
  - CLEAR -> IDLE in the cycle after the counter reaches SPRITES*LINES-1.
  - clear_req while in CLEAR is ignored.
- During CLEAR, all port reads and writes are ignored; rvalid0 and rvalid1 stay 0.
- clear_busy = 1 exactly while state = CLEAR.
- Reset asserted mid-clear aborts the clear. The clear restarts from line 0 after release when CLEAR_ON_RESET=1. Otherwise the array contents are undefined.
- Array contents are never reset asynchronously.

## Timing
- Reset values: data_r0=0, data_r1=0, rvalid0=0, rvalid1=0, clear_busy=CLEAR_ON_RESET, state per above.
- Read latency is 1 cycle. A read accepted at edge N presents data and rvalid=1 after edge N. rvalid is held high for one cycle only. data_r holds its last value otherwise.
- Writes commit at the accepting edge.
- Read-during-write to the same line, on either port or across ports: the read returns the old data.
- Full clear takes SPRITES*LINES cycles; 2048 with the defaults.
- No backpressure. Every accepted request completes at fixed latency.

## Test plan
- Reset with defaults, then idle: clear_busy=1 for exactly 2048 cycles, then 0. A port-1 read of sprite 127 line 15 returns 0x0000 with rvalid1 one cycle later.
- Port-0 write of sprite 5 word 3 with data 0xBEEF_1234, be0=0xF: port 1 then reads line 6 = 0x1234 and line 7 = 0xBEEF. A port-0 read of the same word returns 0xBEEF1234.
- Port-1 write of sprite 9 line 2 with data 0xAB00, be1=2'b10, over existing 0x1111: the line reads back as 0xAB11.
- Both ports write sprite 3 line 0 in the same cycle. Port 0 writes word 0 with data 0x0000_00AA, be0=0x1; port 1 writes 0xCC55 with be1=2'b11. Line 0 reads back as 0xCCAA.
- Assert clear_req, then issue a port-0 write to sprite 1 during the clear: the write is dropped. After clear_busy falls, sprite 1 reads back 0 and rvalid stays low for the whole clear.
- Assert reset at clear cycle 1000: clear_busy stays 1 during reset. After release there are 2048 further busy cycles. A read of sprite 0 line 0, written before the clear, returns 0.

Source files
------------

// File: rtl/sprite_ram_dp.sv
// Dual-port sprite pattern store: wide byte-enabled bus port, narrow renderer port,
// registered reads with valid strobes and a sequential clear engine.
module sprite_ram_dp #(
    parameter int SPRITES        = 128,
    parameter int LINES          = 16,
    parameter int LINE_W         = 16,
    parameter int RATIO          = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                               CLK_100,
    input  logic                               reset,
    input  logic [$clog2(SPRITES)-1:0]         addr0_sprite_index,
    input  logic [$clog2(LINES/RATIO)-1:0]     addr0_sprite_word,
    input  logic [LINE_W*RATIO/8-1:0]          be0,
    input  logic [LINE_W*RATIO-1:0]            data_w0,
    input  logic                               r0,
    input  logic                               w0,
    input  logic                               cs0,
    output logic [LINE_W*RATIO-1:0]            data_r0,
    output logic                               rvalid0,
    input  logic [$clog2(SPRITES)-1:0]         addr1_sprite_index,
    input  logic [$clog2(LINES)-1:0]           addr1_sprite_line,
    input  logic [LINE_W/8-1:0]                be1,
    input  logic [LINE_W-1:0]                  data_w1,
    input  logic                               r1,
    input  logic                               w1,
    output logic [LINE_W-1:0]                  data_r1,
    output logic                               rvalid1,
    input  logic                               clear_req,
    output logic                               clear_busy
);

    localparam int DEPTH = SPRITES * LINES;
    localparam int AW    = $clog2(DEPTH);
    localparam int BPL   = LINE_W / 8;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic            rd0;
    logic            wr0;
    logic            rd1;
    logic            wr1;

    logic [LINE_W-1:0] mem [DEPTH];

    assign clear_busy = (state_q == CLEAR);

    // A read on the same port takes priority over a simultaneous write.
    assign rd0 = !clear_busy && cs0 && r0;
    assign wr0 = !clear_busy && cs0 && w0 && !r0;
    assign rd1 = !clear_busy && r1;
    assign wr1 = !clear_busy && w1 && !r1;

    assign a0 = AW'(addr0_sprite_index) * AW'(LINES)
              + AW'(addr0_sprite_word) * AW'(RATIO);
    assign a1 = AW'(addr1_sprite_index) * AW'(LINES)
              + AW'(addr1_sprite_line);

    always_ff @(posedge CLK_100 or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port 1 is written first so that port 0's later assignments win collisions.
    always_ff @(posedge CLK_100) begin
        if (clear_busy) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr1) begin
                for (int b = 0; b < BPL; b++) begin
                    if (be1[b]) begin
                        mem[a1][8*b +: 8] <= data_w1[8*b +: 8];
                    end
                end
            end
            if (wr0) begin
                for (int i = 0; i < RATIO; i++) begin
                    for (int b = 0; b < BPL; b++) begin
                        if (be0[i*BPL + b]) begin
                            mem[a0 + AW'(i)][8*b +: 8] <=
                                data_w0[i*LINE_W + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_100 or posedge reset) begin
        if (reset) begin
            data_r0 <= '0;
            data_r1 <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            if (rd0) begin
                for (int i = 0; i < RATIO; i++) begin
                    data_r0[i*LINE_W +: LINE_W] <= mem[a0 + AW'(i)];
                end
            end
            if (rd1) begin
                data_r1 <= mem[a1];
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_dp.sv
// Directed testbench for sprite_ram_dp with default parameters.
module tb_sprite_ram_dp;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  addr0_sprite_index;
    logic [2:0]  addr0_sprite_word;
    logic [3:0]  be0;
    logic [31:0] data_w0;
    logic        r0, w0, cs0;
    logic [31:0] data_r0;
    logic        rvalid0;
    logic [6:0]  addr1_sprite_index;
    logic [3:0]  addr1_sprite_line;
    logic [1:0]  be1;
    logic [15:0] data_w1;
    logic        r1, w1;
    logic [15:0] data_r1;
    logic        rvalid1;
    logic        clear_req;
    logic        clear_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_ram_dp dut (
        .CLK_100(clk), .reset(reset),
        .addr0_sprite_index(addr0_sprite_index),
        .addr0_sprite_word(addr0_sprite_word),
        .be0(be0), .data_w0(data_w0),
        .r0(r0), .w0(w0), .cs0(cs0),
        .data_r0(data_r0), .rvalid0(rvalid0),
        .addr1_sprite_index(addr1_sprite_index),
        .addr1_sprite_line(addr1_sprite_line),
        .be1(be1), .data_w1(data_w1),
        .r1(r1), .w1(w1),
        .data_r1(data_r1), .rvalid1(rvalid1),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        r0 = 0; w0 = 0; cs0 = 0; r1 = 0; w1 = 0; clear_req = 0;
        be0 = '0; be1 = '0; data_w0 = '0; data_w1 = '0;
        addr0_sprite_index = '0; addr0_sprite_word = '0;
        addr1_sprite_index = '0; addr1_sprite_line = '0;
    endtask

    task automatic p0_wr(input logic [6:0] s, input logic [2:0] wd,
                         input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr0_sprite_index = s; addr0_sprite_word = wd;
        data_w0 = d; be0 = be; cs0 = 1; w0 = 1;
        @(posedge clk); #1;
        cs0 = 0; w0 = 0;
    endtask

    task automatic p1_wr(input logic [6:0] s, input logic [3:0] ln,
                         input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        addr1_sprite_index = s; addr1_sprite_line = ln;
        data_w1 = d; be1 = be; w1 = 1;
        @(posedge clk); #1;
        w1 = 0;
    endtask

    task automatic p1_rd(input string tag, input logic [6:0] s,
                         input logic [3:0] ln, input logic [15:0] exp);
        @(negedge clk);
        addr1_sprite_index = s; addr1_sprite_line = ln; r1 = 1;
        @(posedge clk); #1;
        r1 = 0;
        check({tag, ".v"}, 64'(rvalid1), 64'd1);
        check(tag, 64'(data_r1), 64'(exp));
    endtask

    task automatic p0_rd(input string tag, input logic [6:0] s,
                         input logic [2:0] wd, input logic [31:0] exp);
        @(negedge clk);
        addr0_sprite_index = s; addr0_sprite_word = wd; cs0 = 1; r0 = 1;
        @(posedge clk); #1;
        cs0 = 0; r0 = 0;
        check({tag, ".v"}, 64'(rvalid0), 64'd1);
        check(tag, 64'(data_r0), 64'(exp));
    endtask

    task automatic wait_clear(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 0;
        while (clear_busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (rvalid0 || rvalid1) saw_valid = 1;
        end
    endtask

    initial begin
        int  n;
        bit  sv;
        idle_inputs();
        reset = 1;
        #1;
        check("rst.busy", 64'(clear_busy), 64'd1);
        check("rst.rv0", 64'(rvalid0), 64'd0);
        check("rst.rv1", 64'(rvalid1), 64'd0);
        check("rst.dr0", 64'(data_r0), 64'd0);
        check("rst.dr1", 64'(data_r1), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        wait_clear(n, sv);
        check("init.cycles", 64'(n), 64'd2048);
        p1_rd("init.last", 7'd127, 4'd15, 16'h0000);
        #1;
        @(posedge clk); #1;
        check("rv1.pulse", 64'(rvalid1), 64'd0);

        p0_wr(7'd5, 3'd3, 32'hBEEF_1234, 4'hF);
        p1_rd("p0w.l6", 7'd5, 4'd6, 16'h1234);
        p1_rd("p0w.l7", 7'd5, 4'd7, 16'hBEEF);
        p0_rd("p0w.rd", 7'd5, 3'd3, 32'hBEEF_1234);
        @(posedge clk); #1;
        check("rv0.pulse", 64'(rvalid0), 64'd0);
        check("dr0.hold", 64'(data_r0), 64'hBEEF_1234);

        p1_wr(7'd9, 4'd2, 16'h1111, 2'b11);
        p1_wr(7'd9, 4'd2, 16'hAB00, 2'b10);
        p1_rd("p1.be", 7'd9, 4'd2, 16'hAB11);

        // Read-during-write across ports returns the old line.
        @(negedge clk);
        addr0_sprite_index = 7'd5; addr0_sprite_word = 3'd3;
        data_w0 = 32'h3333_2222; be0 = 4'hF; cs0 = 1; w0 = 1;
        addr1_sprite_index = 7'd5; addr1_sprite_line = 4'd6; r1 = 1;
        @(posedge clk); #1;
        cs0 = 0; w0 = 0; r1 = 0;
        check("rdw.old", 64'(data_r1), 64'h1234);
        p1_rd("rdw.new", 7'd5, 4'd6, 16'h2222);

        // Read and write together on port 1: write is dropped.
        @(negedge clk);
        addr1_sprite_index = 7'd9; addr1_sprite_line = 4'd2;
        data_w1 = 16'h7777; be1 = 2'b11; r1 = 1; w1 = 1;
        @(posedge clk); #1;
        r1 = 0; w1 = 0;
        check("rw.rd", 64'(data_r1), 64'hAB11);
        p1_rd("rw.drop", 7'd9, 4'd2, 16'hAB11);

        // Simultaneous write collision.
        @(negedge clk);
        addr0_sprite_index = 7'd3; addr0_sprite_word = 3'd0;
        data_w0 = 32'h0000_00AA; be0 = 4'h1; cs0 = 1; w0 = 1;
        addr1_sprite_index = 7'd3; addr1_sprite_line = 4'd0;
        data_w1 = 16'hCC55; be1 = 2'b11; w1 = 1;
        @(posedge clk); #1;
        cs0 = 0; w0 = 0; w1 = 0;
        p1_rd("coll", 7'd3, 4'd0, 16'hCCAA);

        // Clear with a dropped write and reads held during it.
        p0_wr(7'd1, 3'd0, 32'h5555_6666, 4'hF);
        p1_rd("pre.s1", 7'd1, 4'd0, 16'h6666);
        @(negedge clk);
        clear_req = 1;
        @(posedge clk); #1;
        clear_req = 0;
        check("clr.busy", 64'(clear_busy), 64'd1);
        addr1_sprite_index = 7'd3; addr1_sprite_line = 4'd0; r1 = 1;
        n = 0;
        sv = 0;
        while (clear_busy && n < 5000) begin
            if (n == 100) begin
                addr0_sprite_index = 7'd1; addr0_sprite_word = 3'd0;
                data_w0 = 32'hFFFF_FFFF; be0 = 4'hF; cs0 = 1; w0 = 1;
            end else if (n == 101) begin
                cs0 = 0; w0 = 0;
            end
            @(posedge clk); #1;
            n++;
            if (rvalid0 || rvalid1) sv = 1;
        end
        r1 = 0;
        check("clr.cycles", 64'(n), 64'd2048);
        check("clr.novalid", 64'(sv), 64'd0);
        p0_rd("clr.s1", 7'd1, 3'd0, 32'h0000_0000);

        // Reset aborts a clear in progress.
        p1_wr(7'd0, 4'd0, 16'h5A5A, 2'b11);
        p1_rd("pre.s0", 7'd0, 4'd0, 16'h5A5A);
        @(negedge clk);
        clear_req = 1;
        @(posedge clk); #1;
        clear_req = 0;
        repeat (1000) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check("rst2.busy", 64'(clear_busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst2.hold", 64'(clear_busy), 64'd1);
        @(negedge clk);
        reset = 0;
        wait_clear(n, sv);
        check("rst2.cycles", 64'(n), 64'd2048);
        p1_rd("rst2.s0", 7'd0, 4'd0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
